// File: rtl/evt_barrier_aligner.sv
// evt_barrier_aligner: holds time-barrier events on enabled channels until every enabled
// channel has one (or a timeout fires), then forwards or absorbs them together.
module evt_barrier_aligner #(
    parameter int              N          = 4,
    parameter int              DATA_W     = 32,
    parameter int              OP_LSB     = 28,
    parameter int              OP_W       = 4,
    parameter logic [OP_W-1:0] BARRIER_OP = 4'h1,
    parameter int              TO_W       = 16,
    parameter int              CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N-1:0]        synch_en_i,
    input  logic [N-1:0]        fwd_barrier_i,
    input  logic [TO_W-1:0]     timeout_i,
    input  logic                clr_i,
    input  logic [N-1:0]        in_valid_i,
    input  logic [N*DATA_W-1:0] in_data_i,
    output logic [N-1:0]        in_ready_o,
    output logic [N-1:0]        out_valid_o,
    output logic [N*DATA_W-1:0] out_data_o,
    input  logic [N-1:0]        out_ready_i,
    output logic                busy_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    epoch_cnt_o,
    output logic [CNT_W-1:0]    timeout_cnt_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;
    state_t          state_q, state_d;
    logic [N-1:0]    en_q, arrived_q, arrived_d, is_bar, aligned;
    logic [TO_W-1:0] to_cnt_q;
    logic            all_in, to_hit, to_ev, epoch_ev;

    assign out_data_o = in_data_i;
    assign busy_o     = state_q != IDLE;
    assign all_in     = arrived_q == en_q;
    assign to_hit     = timeout_i != '0 && to_cnt_q == timeout_i - 1'b1;
    assign to_ev      = state_q == WAIT && !all_in && to_hit;
    assign epoch_ev   = state_q == RELEASE && state_d == IDLE;

    // Held barriers stay on the upstream port (in_ready low), so the output data is
    // always the input data; only valid/ready are steered per channel.
    always_comb begin
        out_valid_o = in_valid_i;
        in_ready_o  = out_ready_i;
        arrived_d   = arrived_q;
        is_bar      = '0;
        aligned     = '0;
        for (int i = 0; i < N; i++) begin
            is_bar[i]  = in_valid_i[i] && in_data_i[i*DATA_W+OP_LSB +: OP_W] == BARRIER_OP;
            aligned[i] = state_q == IDLE ? synch_en_i[i] : en_q[i];
            if (state_q == RELEASE && arrived_q[i]) begin
                out_valid_o[i] = fwd_barrier_i[i];
                in_ready_o[i]  = fwd_barrier_i[i] ? out_ready_i[i] : 1'b1;
                arrived_d[i]   = fwd_barrier_i[i] && !out_ready_i[i];
            end else if (rst_ni && (arrived_q[i] || (aligned[i] && is_bar[i]))) begin
                out_valid_o[i] = 1'b0;
                in_ready_o[i]  = 1'b0;
                arrived_d[i]   = state_q != RELEASE;
            end
        end
        state_d = state_q == IDLE ? (|arrived_d ? WAIT : IDLE) :
                  state_q == WAIT ? (all_in || to_hit ? RELEASE : WAIT) :
                  (|arrived_d ? RELEASE : IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            en_q          <= '0;
            arrived_q     <= '0;
            to_cnt_q      <= '0;
            timeout_o     <= 1'b0;
            epoch_cnt_o   <= '0;
            timeout_cnt_o <= '0;
        end else begin
            state_q       <= state_d;
            arrived_q     <= to_ev ? arrived_q : arrived_d;
            en_q          <= state_q == IDLE && state_d == WAIT ? synch_en_i : en_q;
            to_cnt_q      <= state_q != WAIT ? '0 : (&to_cnt_q ? to_cnt_q : to_cnt_q + 1'b1);
            timeout_o     <= clr_i ? 1'b0 : timeout_o | to_ev;
            timeout_cnt_o <= clr_i ? '0 : timeout_cnt_o + CNT_W'(to_ev);
            epoch_cnt_o   <= clr_i ? '0 : epoch_cnt_o + CNT_W'(epoch_ev);
        end
    end
endmodule

// File: tb/tb_evt_barrier_aligner.sv
// tb_evt_barrier_aligner: directed vectors with hand-computed expectations for the
// barrier aligner (N=4); cycle 0 of each scenario is the cycle its first barrier appears.
module tb_evt_barrier_aligner;
    localparam logic [31:0] BAR = 32'h1000_0b00;
    localparam logic [31:0] DAT = 32'h2000_0000;

    logic         clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0;
    logic [3:0]   synch_en = '0, fwd = '0, in_valid = '0, out_ready = '0;
    logic [3:0]   in_ready, out_valid;
    logic [15:0]  timeout = '0;
    logic [127:0] in_data, out_data;
    logic         busy, timeout_flag;
    logic [15:0]  epoch_cnt, timeout_cnt;
    logic [31:0]  din [4];
    int           n_vec = 0, n_err = 0;

    assign in_data = {din[3], din[2], din[1], din[0]};

    evt_barrier_aligner dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .synch_en_i(synch_en), .fwd_barrier_i(fwd),
        .timeout_i(timeout), .clr_i(clr_i), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_ready_i(out_ready), .busy_o(busy), .timeout_o(timeout_flag),
        .epoch_cnt_o(epoch_cnt), .timeout_cnt_o(timeout_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (2) nxt;
        rst_ni = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_epoch", epoch_cnt, 0);
        check("rst_tcnt", timeout_cnt, 0);
        check("rst_tflag", timeout_flag, 0);

        // all four barriers together; ch0/ch2 forwarded, ch1/ch3 absorbed
        synch_en = 4'hF; fwd = 4'h5; out_ready = 4'hF;
        nxt; for (int i = 0; i < 4; i++) din[i] = BAR + i; in_valid = 4'hF; #1;
        check("t1_c0_ov", out_valid, 4'h0);
        check("t1_c0_rdy", in_ready, 4'h0);
        nxt; #1;
        check("t1_c1_busy", busy, 1);
        check("t1_c1_ov", out_valid, 4'h0);
        nxt; #1;
        check("t1_c2_ov", out_valid, 4'h5);
        check("t1_c2_rdy", in_ready, 4'hF);
        check("t1_c2_d2", out_data[64 +: 32], BAR + 2);
        nxt; in_valid = '0; #1;
        check("t1_c3_busy", busy, 0);
        check("t1_c3_epoch", epoch_cnt, 1);

        // staggered arrival; unaligned ch2 data flows with zero latency
        synch_en = 4'h3; fwd = 4'h3;
        for (int c = 0; c < 7; c++) begin
            nxt;
            if (c == 0) begin din[0] = BAR; in_valid[0] = 1'b1; end
            if (c == 5) begin din[1] = BAR + 1; in_valid[1] = 1'b1; end
            din[2] = DAT + c; in_valid[2] = 1'b1;
            #1;
            check($sformatf("t2_c%0d_ov", c), out_valid, 4'b0100);
            check($sformatf("t2_c%0d_d2", c), out_data[64 +: 32], DAT + c);
        end
        nxt; #1;
        check("t2_c7_ov", out_valid, 4'b0111);
        check("t2_c7_d1", out_data[32 +: 32], BAR + 1);
        nxt; in_valid = '0; #1;
        check("t2_c8_busy", busy, 0);
        check("t2_c8_epoch", epoch_cnt, 2);

        // timeout release, then ch1 opens a fresh epoch
        timeout = 16'd10;
        nxt; din[0] = BAR; in_valid = 4'b0001; #1;
        repeat (9) nxt;
        nxt; #1;
        check("t3_c10_ov", out_valid, 4'h0);
        check("t3_c10_tflag", timeout_flag, 0);
        nxt; #1;
        check("t3_c11_ov", out_valid, 4'h1);
        check("t3_c11_tflag", timeout_flag, 1);
        check("t3_c11_tcnt", timeout_cnt, 1);
        nxt; din[1] = BAR + 1; in_valid = 4'b0010; #1;
        check("t3_c12_busy", busy, 0);
        check("t3_c12_epoch", epoch_cnt, 3);
        check("t3_c12_ov", out_valid, 4'h0);
        nxt; in_valid = 4'b0011; #1;
        check("t3_c13_busy", busy, 1);
        nxt; #1;
        check("t3_c14_ov", out_valid, 4'h0);
        nxt; #1;
        check("t3_c15_ov", out_valid, 4'h3);
        nxt; in_valid = '0; timeout = '0; #1;
        check("t3_c16_epoch", epoch_cnt, 4);
        check("t3_c16_tcnt", timeout_cnt, 1);

        // downstream backpressure during RELEASE
        synch_en = 4'h1; fwd = 4'h1; out_ready = 4'h0;
        nxt; din[0] = BAR + 7; in_valid = 4'b0001; #1;
        nxt; #1;
        for (int c = 2; c < 7; c++) begin
            nxt; #1;
            check($sformatf("t4_c%0d_ov", c), out_valid, 4'h1);
            check($sformatf("t4_c%0d_d0", c), out_data[0 +: 32], BAR + 7);
            check($sformatf("t4_c%0d_rdy", c), in_ready, 4'h0);
        end
        nxt; out_ready = 4'hF; #1;
        check("t4_c7_rdy", in_ready, 4'hF);
        nxt; in_valid = '0; #1;
        check("t4_c8_busy", busy, 0);
        check("t4_c8_epoch", epoch_cnt, 5);

        // synch_en change mid-WAIT must not shrink the barrier set
        synch_en = 4'h3; fwd = 4'h3;
        nxt; din[0] = BAR; in_valid = 4'b0001; #1;
        nxt; synch_en = 4'h1; #1;
        nxt; nxt; #1;
        check("t5_c3_busy", busy, 1);
        check("t5_c3_ov", out_valid, 4'h0);
        nxt; din[1] = BAR + 1; in_valid = 4'b0011; #1;
        nxt; #1;
        check("t5_c5_ov", out_valid, 4'h0);
        nxt; #1;
        check("t5_c6_ov", out_valid, 4'h3);
        nxt; in_valid = '0; synch_en = 4'h3; #1;
        check("t5_c7_epoch", epoch_cnt, 6);

        // reset mid-WAIT, then clear coinciding with a release
        synch_en = 4'h1; fwd = 4'h1;
        nxt; din[0] = BAR; in_valid = 4'b0001; #1;
        nxt; #1;
        check("t6_wait_busy", busy, 1);
        nxt; rst_ni = 1'b0; in_valid = '0; #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ov", out_valid, 4'h0);
        check("t6_rst_epoch", epoch_cnt, 0);
        check("t6_rst_tcnt", timeout_cnt, 0);
        check("t6_rst_tflag", timeout_flag, 0);
        nxt; rst_ni = 1'b1; #1;
        nxt; in_valid = 4'b0001; #1;
        check("t6_c0_ov", out_valid, 4'h0);
        nxt; #1;
        nxt; clr_i = 1'b1; #1;
        check("t6_c2_ov", out_valid, 4'h1);
        nxt; clr_i = 1'b0; in_valid = '0; #1;
        check("t6_c3_epoch", epoch_cnt, 0);
        check("t6_c3_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
